// File: rtl/vga_mem_pkg.sv
// Shared constants and the access-owner encoding for the VGA image-memory arbiter.
package vga_mem_pkg;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 8;
    localparam int MAX_ADDR = 9999;

    // Owner of the RAM access issued in the current cycle
    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_VGA  = 2'd1,
        OWN_DEC  = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_read_tag_pipe.sv
// Two-deep tag pipeline that follows each read through the RAM latency and
// steers the returned data to the requester that issued it.
module mem_read_tag_pipe
    import vga_mem_pkg::*;
#(
    parameter int DATA_W = vga_mem_pkg::DATA_W
) (
    input  logic              clk_25Mhz,
    input  logic              rst,
    input  logic              issue_vld,
    input  owner_e            issue_owner,
    input  logic              issue_oob,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              vga_rvalid,
    output logic              dec_rvalid
);

    logic   vld_p1;
    logic   vld_p2;
    owner_e own_p1;
    owner_e own_p2;
    logic   oob_p1;
    logic   oob_p2;

    // Valid bits and returned data; reset drops any read still in flight
    always_ff @(posedge clk_25Mhz) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            vga_rvalid <= 1'b0;
            dec_rvalid <= 1'b0;
            rd_data    <= '0;
        end else begin
            // p1: tag captured at the grant edge, RAM sees the address
            vld_p1     <= issue_vld;
            // p2: RAM has registered its output, mem_rdata is valid now
            vld_p2     <= vld_p1;
            // return: data captured and rvalid routed to the issuer
            vga_rvalid <= vld_p2 && (own_p2 == OWN_VGA);
            dec_rvalid <= vld_p2 && (own_p2 == OWN_DEC);
            if (vld_p2) begin
                rd_data <= oob_p2 ? '0 : mem_rdata;
            end
        end
    end

    // Tag payload travels beside the valid bits and is only qualified by them
    always_ff @(posedge clk_25Mhz) begin
        own_p1 <= issue_owner;
        oob_p1 <= issue_oob;
        own_p2 <= own_p1;
        oob_p2 <= oob_p1;
    end

endmodule

// File: rtl/vga_mem_arbiter.sv
// Single-port image RAM arbiter between the VGA display fetch and the
// decrypter. VGA has priority, bounded by a starvation counter that forces a
// decrypter grant after STARVE_LIMIT consecutive VGA wins.
module vga_mem_arbiter
    import vga_mem_pkg::*;
#(
    parameter int ADDR_W       = vga_mem_pkg::ADDR_W,
    parameter int DATA_W       = vga_mem_pkg::DATA_W,
    parameter int MAX_ADDR     = vga_mem_pkg::MAX_ADDR,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_25Mhz,
    input  logic              rst,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    input  logic              dec_req,
    input  logic              dec_we,
    input  logic [ADDR_W-1:0] dec_addr,
    input  logic [DATA_W-1:0] dec_wdata,
    output logic              dec_gnt,
    output logic              dec_rvalid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_oob
);

    localparam int               CNT_W        = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] STARVE_MAX   = CNT_W'(STARVE_LIMIT);
    localparam logic [63:0]      MAX_ADDR_EXT = 64'(MAX_ADDR);

    // Addresses past the image are still granted but never touch the RAM
    function automatic logic addr_oob(input logic [ADDR_W-1:0] addr);
        return 64'(addr) > MAX_ADDR_EXT;
    endfunction

    owner_e            owner;
    owner_e            owner_nxt;
    logic [CNT_W-1:0]  starve_cnt;
    logic [CNT_W-1:0]  starve_nxt;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_write;
    logic              sel_oob;
    logic              issue_rd;

    // Grant decision and starvation bookkeeping from the sampled requests
    always_comb begin
        owner_nxt  = OWN_IDLE;
        starve_nxt = starve_cnt;
        if (!rst) begin
            if (vga_req && dec_req) begin
                owner_nxt = (starve_cnt == STARVE_MAX) ? OWN_DEC : OWN_VGA;
            end else if (vga_req) begin
                owner_nxt = OWN_VGA;
            end else if (dec_req) begin
                owner_nxt = OWN_DEC;
            end
        end
        if (!dec_req || owner_nxt == OWN_DEC) begin
            starve_nxt = '0;
        end else if (owner_nxt == OWN_VGA && starve_cnt != STARVE_MAX) begin
            starve_nxt = starve_cnt + CNT_W'(1);
        end
    end

    // Owner and starvation counter registers
    always_ff @(posedge clk_25Mhz) begin
        if (rst) begin
            owner      <= OWN_IDLE;
            starve_cnt <= '0;
        end else begin
            owner      <= owner_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Mux the winning requester onto the RAM port; idle cycles keep the address
    always_comb begin
        sel_addr  = mem_addr;
        sel_wdata = mem_wdata;
        sel_write = 1'b0;
        case (owner_nxt)
            OWN_VGA: begin
                sel_addr = vga_addr;
            end
            OWN_DEC: begin
                sel_addr  = dec_addr;
                sel_write = dec_we;
                if (dec_we) begin
                    sel_wdata = dec_wdata;
                end
            end
            default: ;
        endcase
        sel_oob  = (owner_nxt != OWN_IDLE) && addr_oob(sel_addr);
        issue_rd = (owner_nxt != OWN_IDLE) && !sel_write;
    end

    // RAM port registers and the sticky out-of-range flag
    always_ff @(posedge clk_25Mhz) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            err_oob   <= 1'b0;
        end else begin
            mem_we <= sel_write && !sel_oob;
            if (owner_nxt != OWN_IDLE) begin
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
            if (sel_oob) begin
                err_oob <= 1'b1;
            end
        end
    end

    assign vga_gnt = (owner == OWN_VGA);
    assign dec_gnt = (owner == OWN_DEC);

    mem_read_tag_pipe #(
        .DATA_W (DATA_W)
    ) u_tag_pipe (
        .clk_25Mhz   (clk_25Mhz),
        .rst         (rst),
        .issue_vld   (issue_rd),
        .issue_owner (owner_nxt),
        .issue_oob   (sel_oob),
        .mem_rdata   (mem_rdata),
        .rd_data     (rd_data),
        .vga_rvalid  (vga_rvalid),
        .dec_rvalid  (dec_rvalid)
    );

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: behavioural RAM, reference arbitration model and
// a read-return scoreboard, plus directed scenarios for the key behaviours.
module tb_vga_mem_arbiter;
    import vga_mem_pkg::*;

    localparam int LIMIT    = 4;
    localparam int MAX_A    = 9999;

    logic        clk_25Mhz = 1'b0;
    logic        rst       = 1'b1;
    logic        vga_req   = 1'b0;
    logic [15:0] vga_addr  = '0;
    logic        vga_gnt;
    logic        vga_rvalid;
    logic        dec_req   = 1'b0;
    logic        dec_we    = 1'b0;
    logic [15:0] dec_addr  = '0;
    logic [7:0]  dec_wdata = '0;
    logic        dec_gnt;
    logic        dec_rvalid;
    logic [7:0]  rd_data;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        err_oob;

    vga_mem_arbiter #(
        .ADDR_W       (16),
        .DATA_W       (8),
        .MAX_ADDR     (MAX_A),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk_25Mhz  (clk_25Mhz),
        .rst        (rst),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_gnt    (vga_gnt),
        .vga_rvalid (vga_rvalid),
        .dec_req    (dec_req),
        .dec_we     (dec_we),
        .dec_addr   (dec_addr),
        .dec_wdata  (dec_wdata),
        .dec_gnt    (dec_gnt),
        .dec_rvalid (dec_rvalid),
        .rd_data    (rd_data),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .err_oob    (err_oob)
    );

    always #20 clk_25Mhz = ~clk_25Mhz;

    // Synchronous single-port RAM with one cycle of read latency
    logic [7:0] ram    [0:65535];
    logic [7:0] shadow [0:65535];
    always @(posedge clk_25Mhz) begin
        mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] = mem_wdata;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    typedef struct {
        owner_e     own;
        logic [7:0] data;
        int         due;
    } rd_t;
    rd_t sb[$];

    // Inputs as the DUT saw them at the last rising edge
    logic        s_rst = 1'b1, s_vreq = 1'b0, s_dreq = 1'b0, s_dwe = 1'b0;
    logic [15:0] s_vaddr = '0, s_daddr = '0;
    logic [7:0]  s_dwdata = '0;
    always @(posedge clk_25Mhz) begin
        s_rst = rst; s_vreq = vga_req; s_dreq = dec_req; s_dwe = dec_we;
        s_vaddr = vga_addr; s_daddr = dec_addr; s_dwdata = dec_wdata;
    end

    int          cyc = 0;
    int          m_starve = 0;
    logic        m_err = 1'b0;
    logic [15:0] m_addr = '0;
    logic [7:0]  m_wdata = '0;

    // Reference model and scoreboard, evaluated mid-cycle
    always @(negedge clk_25Mhz) begin
        owner_e      own;
        logic        oob, wr, exp_we;
        logic [15:0] a;
        rd_t         e;
        cyc++;
        if (s_rst) begin
            sb.delete();
            m_starve = 0; m_err = 1'b0; m_addr = '0; m_wdata = '0;
            check("rst_ctrl", {26'd0, vga_gnt, dec_gnt, vga_rvalid, dec_rvalid, mem_we, err_oob}, 32'd0);
            check("rst_data", {rd_data, mem_addr, mem_wdata}, 32'd0);
        end else begin
            own = OWN_IDLE;
            if (s_vreq && s_dreq) own = (m_starve == LIMIT) ? OWN_DEC : OWN_VGA;
            else if (s_vreq)      own = OWN_VGA;
            else if (s_dreq)      own = OWN_DEC;
            if (!s_dreq || own == OWN_DEC) m_starve = 0;
            else if (own == OWN_VGA && m_starve < LIMIT) m_starve++;
            exp_we = 1'b0;
            if (own != OWN_IDLE) begin
                a   = (own == OWN_VGA) ? s_vaddr : s_daddr;
                wr  = (own == OWN_DEC) && s_dwe;
                oob = (int'(a) > MAX_A);
                if (oob) m_err = 1'b1;
                m_addr = a;
                if (wr) begin
                    m_wdata = s_dwdata;
                    if (!oob) begin
                        shadow[a] = s_dwdata;
                        exp_we = 1'b1;
                    end
                end else begin
                    e.own  = own;
                    e.data = oob ? 8'h00 : shadow[a];
                    e.due  = cyc + 2;
                    sb.push_back(e);
                end
            end
            check("vga_gnt", {31'd0, vga_gnt}, {31'd0, own == OWN_VGA});
            check("dec_gnt", {31'd0, dec_gnt}, {31'd0, own == OWN_DEC});
            check("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
            check("mem_addr", {16'd0, mem_addr}, {16'd0, m_addr});
            check("mem_wdata", {24'd0, mem_wdata}, {24'd0, m_wdata});
            check("err_oob", {31'd0, err_oob}, {31'd0, m_err});
            if (vga_rvalid || dec_rvalid) begin
                if (sb.size() == 0) begin
                    check("rvalid_unexpected", {30'd0, vga_rvalid, dec_rvalid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rd_owner", {30'd0, vga_rvalid, dec_rvalid},
                          (e.own == OWN_VGA) ? 32'd2 : 32'd1);
                    check("rd_latency", cyc, e.due);
                    check("rd_data", {24'd0, rd_data}, {24'd0, e.data});
                end
            end
            while (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                check("rd_missing", cyc, e.due);
            end
        end
    end

    task automatic tick();
        @(posedge clk_25Mhz);
        #1;
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 19) == 0) return 16'(9998 + $urandom_range(0, 3));
        return 16'($urandom_range(0, 31));
    endfunction

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i]    = 8'(i * 7 + 3);
            shadow[i] = ram[i];
        end
        ram[5]    = 8'hA3;
        shadow[5] = 8'hA3;

        // reset
        tick(); tick();
        check("init_gnt", {30'd0, vga_gnt, dec_gnt}, 32'd0);
        check("init_mem_addr", {16'd0, mem_addr}, 32'd0);
        rst = 1'b0;
        tick();

        // single VGA read, latency 2
        vga_req = 1'b1; vga_addr = 16'd5;
        tick();
        check("v_gnt", {31'd0, vga_gnt}, 32'd1);
        check("v_addr", {16'd0, mem_addr}, 32'd5);
        vga_req = 1'b0;
        tick();
        check("v_rvalid_early", {31'd0, vga_rvalid}, 32'd0);
        tick();
        check("v_rvalid", {31'd0, vga_rvalid}, 32'd1);
        check("v_data", {24'd0, rd_data}, 32'hA3);

        // both requesting continuously: V,V,V,V,D repeating
        vga_req = 1'b1; vga_addr = 16'd0;
        dec_req = 1'b1; dec_we = 1'b0; dec_addr = 16'd1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("starve_pattern", {30'd0, vga_gnt, dec_gnt}, (i % 5 == 4) ? 32'd1 : 32'd2);
            if (vga_gnt) vga_addr = vga_addr + 16'd1;
            if (dec_gnt) dec_addr = dec_addr + 16'd2;
        end
        vga_req = 1'b0; dec_req = 1'b0;
        tick(); tick(); tick();

        // decrypter write then VGA read of the same pixel
        dec_req = 1'b1; dec_we = 1'b1; dec_addr = 16'd20; dec_wdata = 8'h5C;
        tick();
        check("w_gnt", {31'd0, dec_gnt}, 32'd1);
        check("w_we", {31'd0, mem_we}, 32'd1);
        check("w_addr", {16'd0, mem_addr}, 32'd20);
        check("w_data", {24'd0, mem_wdata}, 32'h5C);
        dec_req = 1'b0; dec_we = 1'b0;
        vga_req = 1'b1; vga_addr = 16'd20;
        tick();
        check("wr_gnt", {31'd0, vga_gnt}, 32'd1);
        check("wr_we_clear", {31'd0, mem_we}, 32'd0);
        vga_req = 1'b0;
        tick(); tick();
        check("wr_rvalid", {31'd0, vga_rvalid}, 32'd1);
        check("wr_data", {24'd0, rd_data}, 32'h5C);

        // out-of-range decrypter read, then range boundary writes
        dec_req = 1'b1; dec_we = 1'b0; dec_addr = 16'd10000;
        tick();
        check("oob_gnt", {31'd0, dec_gnt}, 32'd1);
        check("oob_we", {31'd0, mem_we}, 32'd0);
        dec_req = 1'b0;
        tick(); tick();
        check("oob_rvalid", {31'd0, dec_rvalid}, 32'd1);
        check("oob_data", {24'd0, rd_data}, 32'd0);
        check("oob_flag", {31'd0, err_oob}, 32'd1);
        dec_req = 1'b1; dec_we = 1'b1; dec_addr = 16'd10001; dec_wdata = 8'hFF;
        tick();
        check("oob_wr_we", {31'd0, mem_we}, 32'd0);
        dec_addr = 16'd9999; dec_wdata = 8'h11;
        tick();
        check("max_wr_we", {31'd0, mem_we}, 32'd1);
        dec_req = 1'b0; dec_we = 1'b0;
        tick(); tick();
        check("oob_sticky", {31'd0, err_oob}, 32'd1);

        // reset one cycle after a VGA grant discards the read
        vga_req = 1'b1; vga_addr = 16'd7;
        dec_req = 1'b1; dec_we = 1'b0; dec_addr = 16'd3;
        tick();
        check("r_gnt", {31'd0, vga_gnt}, 32'd1);
        check("r_starve_pre", 32'(dut.starve_cnt), 32'd1);
        rst = 1'b1;
        tick();
        check("r_outs", {30'd0, vga_gnt, dec_gnt}, 32'd0);
        check("r_flag", {31'd0, err_oob}, 32'd0);
        check("r_addr", {16'd0, mem_addr}, 32'd0);
        check("r_starve", 32'(dut.starve_cnt), 32'd0);
        rst = 1'b0; vga_req = 1'b0; dec_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("r_no_rvalid", {30'd0, vga_rvalid, dec_rvalid}, 32'd0);
        end

        // random traffic honouring the request/grant handshake
        for (int i = 0; i < 400; i++) begin
            if (!vga_req || vga_gnt) begin
                vga_req  = ($urandom_range(0, 3) != 0);
                vga_addr = rand_addr();
            end
            if (!dec_req || dec_gnt) begin
                dec_req   = ($urandom_range(0, 2) != 0);
                dec_we    = $urandom_range(0, 1) == 1;
                dec_addr  = rand_addr();
                dec_wdata = 8'($urandom_range(0, 255));
            end
            tick();
        end
        vga_req = 1'b0; dec_req = 1'b0;
        tick(); tick(); tick(); tick();
        check("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_mem_arbiter.md
VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 The block SHALL have one clock, clk_25Mhz; reset is rst, synchronous and active-high.
REQ-002 Parameter ADDR_W, default 16: address width of the image memory and of all requesters.
REQ-003 Parameter DATA_W, default 8: pixel/data width.
REQ-004 Parameter MAX_ADDR, default 9999: highest valid address (100x100 image).
REQ-005 Parameter STARVE_LIMIT, default 4: consecutive VGA grants allowed while dec_req is pending.
REQ-006 clk_25Mhz  in  1  pixel clock; all logic on its rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 vga_req  in  1  display fetch request; held until vga_gnt.
REQ-009 vga_addr  in  ADDR_W  display read address; stable while vga_req is high.
REQ-010 vga_gnt  out  1  one-cycle pulse; the VGA access is issued.
REQ-011 vga_rvalid  out  1  one-cycle pulse; rd_data holds the VGA read result.
REQ-012 dec_req  in  1  decrypter request; held until dec_gnt.
REQ-013 dec_we  in  1  1 = write, 0 = read; stable while dec_req is high.
REQ-014 dec_addr  in  ADDR_W  decrypter address.
REQ-015 dec_wdata  in  DATA_W  decrypter write data.
REQ-016 dec_gnt  out  1  one-cycle pulse; the decrypter access is issued.
REQ-017 dec_rvalid  out  1  one-cycle pulse; rd_data holds the decrypter read result.
REQ-018 rd_data  out  DATA_W  registered read data shared by both requesters.
REQ-019 mem_addr  out  ADDR_W  registered single-port RAM address.
REQ-020 mem_we  out  1  registered RAM write enable.
REQ-021 mem_wdata  out  DATA_W  registered RAM write data.
REQ-022 mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_addr is presented.
REQ-023 err_oob  out  1  sticky flag for an out-of-range access.

Function
REQ-024 Arbitration SHALL be decided at each rising edge from the sampled requests: at most one grant per cycle, and one access per cycle back-to-back.
REQ-025 Owner state SHALL be IDLE/VGA/DEC, recording the owner of the access issued this cycle: IDLE when no request, VGA on vga_gnt, DEC on dec_gnt.
REQ-026 When both requests are high, VGA SHALL win unless starve_cnt == STARVE_LIMIT; in that case DEC wins and starve_cnt is cleared.
REQ-027 starve_cnt SHALL increment on each VGA grant while dec_req is high (saturating at STARVE_LIMIT) and clear when dec_req is low or DEC is granted.
REQ-028 On a grant at edge k, mem_addr, mem_we and mem_wdata SHALL hold the granted access from edge k to edge k+1; mem_we SHALL be 1 only for a DEC write.
REQ-029 For a read granted at edge k, rd_data SHALL capture mem_rdata at edge k+2, and the matching rvalid SHALL pulse high for the cycle after edge k+2 (latency 2).
REQ-030 A 2-deep owner tag pipeline SHALL route each rvalid to the issuing requester; read results SHALL be returned in issue order.
REQ-031 An address > MAX_ADDR SHALL still be granted but SHALL drive mem_we = 0. A read SHALL return rd_data = 0 with the normal rvalid timing. A write SHALL be dropped. err_oob SHALL set.
REQ-032 A cycle with no grant SHALL drive mem_we = 0 and hold mem_addr unchanged.
REQ-033 Requesters SHALL be able to drop and re-raise req in the cycle after gnt; a new request SHALL be grantable in the very next cycle.

Reset
REQ-034 When rst is high at an edge, all of the following SHALL be 0 from the next cycle: vga_gnt, dec_gnt, vga_rvalid, dec_rvalid, rd_data, mem_addr, mem_we, mem_wdata, err_oob and starve_cnt; the owner state SHALL be IDLE.
REQ-035 In-flight reads at reset SHALL be discarded with no rvalid; no grant SHALL issue while rst is high.

Structure
REQ-036 Package vga_mem_pkg SHALL hold ADDR_W, DATA_W, MAX_ADDR and the owner_e enum {OWN_IDLE, OWN_VGA, OWN_DEC}.
REQ-037 The tag pipeline SHALL be the sub-module mem_read_tag_pipe; the arbitration and starvation logic stay in vga_mem_arbiter.

Verification
REQ-038 VGA read only: vga_req=1, vga_addr=5, RAM[5]=0xA3 -> vga_gnt at edge k, rd_data=0xA3 with vga_rvalid at edge k+2.
REQ-039 Both requesting continuously, dec_we=0, STARVE_LIMIT=4 -> grant pattern V,V,V,V,D repeating; every read returns in issue order.
REQ-040 DEC write addr 20 data 0x5C, then VGA read addr 20 -> mem_we=1 for one cycle, then rd_data=0x5C with vga_rvalid.
REQ-041 DEC read addr 10000 -> dec_gnt, mem_we=0, dec_rvalid with rd_data=0x00, err_oob=1 and remaining 1 until rst.
REQ-042 rst asserted one cycle after a VGA grant -> no vga_rvalid for that read; all outputs 0 and starve_cnt=0 after the reset edge.
